// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared definitions for the EX-stage mult/div issue sequencer: op codes, state encoding, op decode.
package mdu_issue_ctrl_pkg;

  localparam int unsigned OP_W   = 5;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned HILO_W = 64;

  // ALU control codes for the HI/LO-producing ops (shared ALU decode).
  localparam logic [OP_W-1:0] ALU_NOP           = 5'd0;
  localparam logic [OP_W-1:0] ALU_SIGNED_MULT   = 5'd12;
  localparam logic [OP_W-1:0] ALU_UNSIGNED_MULT = 5'd13;
  localparam logic [OP_W-1:0] ALU_SIGNED_DIV    = 5'd14;
  localparam logic [OP_W-1:0] ALU_UNSIGNED_DIV  = 5'd15;

  typedef enum logic [1:0] {
    MDU_IDLE      = 2'd0,
    MDU_MULT_BUSY = 2'd1,
    MDU_DIV_BUSY  = 2'd2,
    MDU_DONE      = 2'd3
  } mdu_state_e;

  function automatic logic is_mult_op(input logic [OP_W-1:0] op);
    return (op == ALU_SIGNED_MULT) || (op == ALU_UNSIGNED_MULT);
  endfunction

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == ALU_SIGNED_DIV) || (op == ALU_UNSIGNED_DIV);
  endfunction

endpackage

// File: rtl/mdu_issue_ctrl_lat_cnt.sv
// Loadable up-counter with terminal-count flag; times the multiplier latency.
module mdu_lat_cnt #(
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned TC_VAL = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             inc_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Clear beats load beats increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CNT_W'(TC_VAL));

endmodule

// File: rtl/mdu_issue_ctrl.sv
// Sequences the EX-stage multiplier and divider: launch, EX stall, {HI,LO} capture and a single
// HI/LO write strobe when the op leaves EX; flushes abandon the op without writing HI/LO.
module mdu_issue_ctrl
  import mdu_issue_ctrl_pkg::*;
#(
  parameter int unsigned MULT_LAT = 9,
  parameter int unsigned CNT_W    = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [OP_W-1:0]   op_i,
  input  logic [XLEN-1:0]   src_a_i,
  input  logic [XLEN-1:0]   src_b_i,
  input  logic              flush_e_i,
  input  logic              flush_exc_i,
  input  logic              stall_m_i,
  output logic              mult_ce_o,
  output logic              mult_sign_o,
  input  logic [HILO_W-1:0] mult_p_i,
  output logic              div_opn_valid_o,
  output logic              div_sign_o,
  output logic              div_abort_o,
  input  logic              div_res_valid_i,
  output logic              div_res_ready_o,
  input  logic [HILO_W-1:0] div_result_i,
  output logic              stall_o,
  output logic [HILO_W-1:0] result_o,
  output logic              hilo_we_o
);

  mdu_state_e        state_d, state_q;
  logic [HILO_W-1:0] result_d, result_q;
  logic              kill;
  logic              cnt_clr, cnt_load, cnt_inc, cnt_tc;

  // Operands go straight from EX to the units; EX holds them stable while stalled.
  logic unused_operands;
  assign unused_operands = ^{src_a_i, src_b_i};

  assign kill = flush_e_i | flush_exc_i;

  mdu_lat_cnt #(
    .CNT_W  (CNT_W),
    .TC_VAL (MULT_LAT - 1)
  ) u_lat_cnt (
    .clk        (clk),
    .resetn     (resetn),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (CNT_W'(1)),
    .inc_i      (cnt_inc),
    .tc_o       (cnt_tc)
  );

  always_comb begin
    state_d         = state_q;
    result_d        = result_q;
    cnt_clr         = 1'b0;
    cnt_load        = 1'b0;
    cnt_inc         = 1'b0;
    mult_ce_o       = 1'b0;
    div_opn_valid_o = 1'b0;
    div_abort_o     = 1'b0;
    div_res_ready_o = 1'b0;
    stall_o         = 1'b0;
    hilo_we_o       = 1'b0;
    mult_sign_o     = (op_i == ALU_SIGNED_MULT);
    div_sign_o      = (op_i == ALU_SIGNED_DIV);

    unique case (state_q)
      MDU_IDLE: begin
        if (!kill && is_mult_op(op_i)) begin
          mult_ce_o = 1'b1;
          stall_o   = 1'b1;
          cnt_load  = 1'b1;
          state_d   = MDU_MULT_BUSY;
        end else if (!kill && is_div_op(op_i)) begin
          div_opn_valid_o = 1'b1;
          stall_o         = 1'b1;
          state_d         = MDU_DIV_BUSY;
        end
      end
      MDU_MULT_BUSY: begin
        mult_ce_o = 1'b1;
        stall_o   = 1'b1;
        if (kill) begin
          cnt_clr = 1'b1;
          state_d = MDU_IDLE;
        end else if (cnt_tc) begin
          cnt_clr  = 1'b1;
          result_d = mult_p_i;
          state_d  = MDU_DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      MDU_DIV_BUSY: begin
        div_opn_valid_o = 1'b1;
        stall_o         = 1'b1;
        if (kill) begin
          // A result arriving with the flush is dropped; the abort clears the divider.
          div_abort_o = 1'b1;
          state_d     = MDU_IDLE;
        end else if (div_res_valid_i) begin
          div_res_ready_o = 1'b1;
          result_d        = div_result_i;
          state_d         = MDU_DONE;
        end
      end
      MDU_DONE: begin
        if (kill) begin
          state_d = MDU_IDLE;
        end else if (!stall_m_i) begin
          hilo_we_o = 1'b1;
          state_d   = MDU_IDLE;
        end
      end
      default: state_d = MDU_IDLE;
    endcase

    if (flush_exc_i) begin
      stall_o = 1'b0;
    end

    // Decoded outputs must not leak the op in EX while reset is asserted.
    if (!resetn) begin
      mult_ce_o       = 1'b0;
      mult_sign_o     = 1'b0;
      div_opn_valid_o = 1'b0;
      div_sign_o      = 1'b0;
      div_abort_o     = 1'b0;
      div_res_ready_o = 1'b0;
      stall_o         = 1'b0;
      hilo_we_o       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= MDU_IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  assign result_o = result_q;

endmodule
